booth_divider_8by4: RTL and testbench
=====================================

Name: booth_divider_8by4

Overview:
- Sequential signed divider: 8-bit dividend / 4-bit divisor → 8-bit quotient, 4-bit remainder.
- Inverse companion of the team's sequential Booth multiplier. Same start/result style, so a bench can round-trip p = a*b back through this block.
- Restoring division on magnitudes, one quotient bit per clock, with sign fix-up at the end.

Parameters:
- none; widths are fixed at 8/4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  8  signed two's-complement dividend
- divisor  input  4  signed two's-complement divisor
- quotient  output  8  signed quotient, truncated toward zero
- remainder  output  4  signed remainder; sign follows dividend
- done  output  1  one-cycle pulse, results valid
- busy  output  1  high whenever state != IDLE
- div_by_zero  output  1  result flag: divisor was 0
- overflow  output  1  result flag: -128 / -1

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, count=0, all internal registers 0.
  - quotient=0, remainder=0, done=0, busy=0, div_by_zero=0, overflow=0.
  - Reset mid-operation aborts the operation; no done pulse is issued.
- States: IDLE, CALC, DONE (2-bit encoding). count is 3 bits.
- IDLE:
  - On an edge with start=1, capture |dividend| as 8-bit unsigned (so -128 → 128).
  - Capture |divisor| as 4-bit unsigned, zero-extended to 5 bits.
  - Capture qneg = dividend[7]^divisor[3] and rneg = dividend[7].
  - Compute dbz = (divisor==0) and ovf = (dividend==8'h80 && divisor==4'hF).
  - Clear the partial remainder R (5 bits); set count=0; go to CALC.
  - start=0: stay in IDLE.
  - Outputs hold their last results.
- CALC, one iteration per edge:
  - T = {R[3:0], Q[7]}; Q is shifted left.
  - If T >= D: R = T-D and Q[0]=1.
  - Else: R = T and Q[0]=0.
  - count increments. At the edge where count==7, the iteration completes and state → DONE.
- DONE, one cycle:
  - done=1.
  - quotient = qneg ? -Q : Q.
  - remainder = rneg ? -R[3:0] : R[3:0].
  - Next edge → IDLE; done returns to 0.
- Result registers load on the CALC→DONE edge and hold until the next DONE.
- Latency is fixed: start sampled at edge E0, CALC iterations at E1..E8, done high between E8 and E9, back in IDLE at E9.
  - The same latency applies to every case, including error cases.
- start while busy (CALC or DONE) is ignored; no queuing.
  - A start present on the DONE→IDLE edge is also ignored; the earliest accepted start is the first edge in IDLE.
- Divide by zero:
  - The iterations run but their result is discarded.
  - quotient=0, remainder=0, div_by_zero=1, overflow=0.
- Overflow (-128/-1):
  - quotient=8'h80, remainder=0, overflow=1, div_by_zero=0.
- Flags update at the DONE edge alongside quotient and remainder, and hold until the next DONE.
- Inputs dividend and divisor may change after the start edge without effect.
- Identity holds for all non-error cases: dividend == quotient*divisor + remainder, with |remainder| < |divisor|.
- -128 / 1 → q=-128, r=0, no flags. -128 / 2 → q=-64, r=0.

Test Plan:
- Reset and quiescence:
  - rst_n=0 asserted mid-CALC → immediately IDLE, all outputs 0, no done.
  - Release reset, then run 100/7 → q=14, r=2, done at E8.
- Signs:
  - -100/7 → q=-14, r=-2.
  - 7/-3 → q=-2, r=1.
  - -7/-3 → q=2, r=-1.
  - Each case: flags 0, done high exactly one cycle, busy high E0..E9.
- Extremes:
  - -128/1 → q=-128, r=0.
  - 127/-8 → q=-15, r=7.
  - -128/-1 → q=8'h80, r=0, overflow=1.
- Divide by zero:
  - 55/0 → q=0, r=0, div_by_zero=1.
  - Latency is still 8 cycles.
  - The following 20/5 → q=4, r=0, flags cleared.
- Handshake:
  - Hold start=1 continuously → back-to-back operations; done pulses every 10 cycles.
  - Pulse start mid-CALC with different operands → ignored; the original result is reported.
- Round-trip:
  - For all dividend in [-128..127] and divisor in [-8..7] with divisor≠0, excluding -128/-1 → check dividend == q*divisor + r and |r| < |divisor|.

Source files
------------

// File: rtl/booth_divider_8by4.sv
// Sequential signed 8/4 divider: restoring division on magnitudes, one quotient
// bit per clock, sign fix-up on the CALC->DONE edge. Companion of the Booth multiplier.
module booth_divider_8by4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       done,
  output logic       busy,
  output logic       div_by_zero,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] count_q, count_d;
  logic [7:0] q_q, q_d;           // dividend magnitude shifting out, quotient bits shifting in
  logic [3:0] r_q, r_d;           // partial remainder; always < |divisor| <= 8, so 4 bits suffice
  logic [4:0] d_q, d_d;           // |divisor|, zero-extended so 8 is representable
  logic       qneg_q, qneg_d;
  logic       rneg_q, rneg_d;
  logic       dbz_q, dbz_d;
  logic       ovf_q, ovf_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       dbz_out_q, dbz_out_d;
  logic       ovf_out_q, ovf_out_d;

  logic [4:0] trial;
  logic       ge;
  logic [3:0] diff;
  logic [7:0] q_iter;
  logic [3:0] r_iter;

  // When trial >= D the true difference is below 8, so 4-bit modular subtraction is exact.
  assign trial  = {r_q, q_q[7]};
  assign ge     = (trial >= d_q);
  assign diff   = trial[3:0] - d_q[3:0];
  assign q_iter = {q_q[6:0], ge};
  assign r_iter = ge ? diff : trial[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    q_d       = q_q;
    r_d       = r_q;
    d_d       = d_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = dividend[7] ? (~dividend + 8'd1) : dividend;
          d_d     = {1'b0, (divisor[3] ? (~divisor + 4'd1) : divisor)};
          r_d     = 4'd0;
          count_d = 3'd0;
          qneg_d  = dividend[7] ^ divisor[3];
          rneg_d  = dividend[7];
          dbz_d   = (divisor == 4'd0);
          ovf_d   = (dividend == 8'h80) && (divisor == 4'hF);
          state_d = CALC;
        end
      end
      CALC: begin
        q_d     = q_iter;
        r_d     = r_iter;
        count_d = count_q + 3'd1;
        if (count_q == 3'd7) begin
          state_d = DONE;
          if (dbz_q) begin
            quot_d    = 8'd0;
            rem_d     = 4'd0;
            dbz_out_d = 1'b1;
            ovf_out_d = 1'b0;
          end else if (ovf_q) begin
            quot_d    = 8'h80;
            rem_d     = 4'd0;
            dbz_out_d = 1'b0;
            ovf_out_d = 1'b1;
          end else begin
            quot_d    = qneg_q ? (~q_iter + 8'd1) : q_iter;
            rem_d     = rneg_q ? (~r_iter + 4'd1) : r_iter;
            dbz_out_d = 1'b0;
            ovf_out_d = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 3'd0;
      q_q       <= 8'd0;
      r_q       <= 4'd0;
      d_q       <= 5'd0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      quot_q    <= 8'd0;
      rem_q     <= 4'd0;
      dbz_out_q <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      q_q       <= q_d;
      r_q       <= r_d;
      d_q       <= d_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;
  assign overflow    = ovf_out_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_booth_divider_8by4.sv
// Scoreboard bench for booth_divider_8by4: driver pushes expected results,
// an independent monitor pops and compares on every done pulse.
module tb_booth_divider_8by4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       done;
  logic       busy;
  logic       div_by_zero;
  logic       overflow;

  booth_divider_8by4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    bit         dbz;
    bit         ovf;
    int         e0;
    int         a;
    int         b;
    bit         idchk;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  initial begin : monitor
    bit   prev_done;
    exp_t e;
    int   qs, rs, ra, rb;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        check("done_one_cycle", int'(prev_done), 0);
        check("busy_at_done", int'(busy), 1);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("latency", cyc - e.e0, 8);
          check("quotient", int'(quotient), int'(e.q));
          check("remainder", int'(remainder), int'(e.r));
          check("div_by_zero", int'(div_by_zero), int'(e.dbz));
          check("overflow", int'(overflow), int'(e.ovf));
          if (e.idchk) begin
            qs = $signed(quotient);
            rs = $signed(remainder);
            ra = (rs < 0) ? -rs : rs;
            rb = (e.b < 0) ? -e.b : e.b;
            check("identity", qs * e.b + rs, e.a);
            check("rem_bound", int'(ra < rb), 1);
          end
          $display("op %0d / %0d -> q=%0d r=%0d dbz=%0b ovf=%0b", e.a, e.b,
                   $signed(quotient), $signed(remainder), div_by_zero, overflow);
        end
      end
      prev_done = rst_n && done;
    end
  end

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) check("idle_timeout", int'(busy), 0);
  endtask

  task automatic issue(input int a, input int b, input logic [7:0] eq, input logic [3:0] er,
                       input bit edbz, input bit eovf, input bit push, input bit idchk);
    exp_t e;
    wait_idle();
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
      e.e0 = cyc + 1; e.a = a; e.b = b; e.idchk = idchk;
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    // Scramble operands after the start edge; the captured values must be used.
    dividend = 8'h5A;
    divisor  = 4'h3;
    check("busy_after_start", int'(busy), 1);
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || busy) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_dbz"}, int'(div_by_zero), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
  endtask

  initial begin : driver
    exp_t e;
    int   n, w, qi, ri;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    issue(-100, 7, 8'hF2, 4'hE, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();

    // Abort an operation mid-CALC with reset: outputs clear, no done follows.
    issue(33, 4, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(100, 7, 8'd14, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(7, -3, 8'hFE, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(-7, -3, 8'd2, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(-128, 1, 8'h80, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(127, -8, 8'hF1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(-128, -1, 8'h80, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    issue(55, 0, 8'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    issue(20, 5, 8'd4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    issue(-128, 2, 8'hC0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // start held high: accepted every 10 cycles.
    wait_idle();
    dividend = 8'd20;
    divisor  = 4'd3;
    start    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e.q = 8'd6; e.r = 4'd2; e.dbz = 1'b0; e.ovf = 1'b0;
      e.e0 = cyc + 1 + 10 * k; e.a = 20; e.b = 3; e.idchk = 1'b1;
      sb.push_back(e);
    end
    n = 0;
    w = 0;
    while (n < 3 && w < 80) begin
      @(negedge clk);
      if (done) n++;
      w++;
    end
    start = 1'b0;
    if (n < 3) check("back_to_back_timeout", n, 3);

    // start pulsed mid-CALC with other operands is ignored.
    issue(50, 6, 8'd8, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    dividend = 8'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Exhaustive round trip against integer division (truncation toward zero).
    for (int a = -128; a < 128; a++) begin
      for (int b = -8; b < 8; b++) begin
        if (b != 0 && !(a == -128 && b == -1)) begin
          qi = a / b;
          ri = a % b;
          issue(a, b, qi[7:0], ri[3:0], 1'b0, 1'b0, 1'b1, 1'b1);
        end
      end
    end

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
